// File: rtl/wshb_arb_pkg.sv
// wshb_arb_pkg: arbiter state encoding and reset constants
package wshb_arb_pkg;
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t;
    localparam logic RESET_LAST = 1'b1;
endpackage

// File: rtl/wshb_if.sv
// wshb_if: Wishbone B4 bus bundle with master/slave views
interface wshb_if #(parameter int DATA_BYTES = 4);
    logic                      cyc;
    logic                      stb;
    logic                      we;
    logic [31:0]               adr;
    logic [8*DATA_BYTES-1:0]   dat_ms;
    logic [8*DATA_BYTES-1:0]   dat_sm;
    logic [DATA_BYTES-1:0]     sel;
    logic [2:0]                cti;
    logic [1:0]                bte;
    logic                      ack;
    logic                      err;
    logic                      rty;
    modport master(output cyc, stb, we, adr, dat_ms, sel, cti, bte, input dat_sm, ack, err, rty);
    modport slave(input cyc, stb, we, adr, dat_ms, sel, cti, bte, output dat_sm, ack, err, rty);
endinterface

// File: rtl/rr_select.sv
// rr_select: two-input round-robin picker favouring the index other than last
module rr_select (
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick,
    output logic       valid
);
    always_comb begin
        valid = |req;
        pick  = &req ? ~last : req[1];
    end
endmodule

// File: rtl/wshb_arbiter.sv
// wshb_arbiter: two-master round-robin Wishbone arbiter holding ownership for a whole cyc
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int DATA_BYTES = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    wshb_if.slave      wshb_ifs0,
    wshb_if.slave      wshb_ifs1,
    wshb_if.master     wshb_ifm,
    output logic [1:0] gnt
);
    arb_state_t state_q, state_d;
    logic       last_q, last_d;
    logic [1:0] req, cand;
    logic       hold, pick, valid, own0, own1;

    assign req = {wshb_ifs1.cyc, wshb_ifs0.cyc};

    rr_select u_rr (
        .req   (cand),
        .last  (last_q),
        .pick  (pick),
        .valid (valid)
    );

    always_comb begin
        hold    = (state_q == GNT0 && req[0]) || (state_q == GNT1 && req[1]);
        cand    = state_q == GNT0 ? {req[1], 1'b0} : state_q == GNT1 ? {1'b0, req[0]} : req;
        state_d = hold ? state_q : valid ? (pick ? GNT1 : GNT0) : IDLE;
        last_d  = state_d == GNT1 ? 1'b1 : state_d == GNT0 ? 1'b0 : last_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            last_q  <= RESET_LAST;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign own0 = state_q == GNT0 && !sys_rst;
    assign own1 = state_q == GNT1 && !sys_rst;
    assign gnt  = {own1, own0};

    assign wshb_ifm.cyc    = own0 ? wshb_ifs0.cyc : own1 ? wshb_ifs1.cyc : 1'b0;
    assign wshb_ifm.stb    = own0 ? wshb_ifs0.cyc & wshb_ifs0.stb : own1 ? wshb_ifs1.cyc & wshb_ifs1.stb : 1'b0;
    assign wshb_ifm.we     = own0 ? wshb_ifs0.we : own1 ? wshb_ifs1.we : 1'b0;
    assign wshb_ifm.adr    = own0 ? wshb_ifs0.adr : own1 ? wshb_ifs1.adr : 32'd0;
    assign wshb_ifm.dat_ms = own0 ? wshb_ifs0.dat_ms : own1 ? wshb_ifs1.dat_ms : {8*DATA_BYTES{1'b0}};
    assign wshb_ifm.sel    = own0 ? wshb_ifs0.sel : own1 ? wshb_ifs1.sel : {DATA_BYTES{1'b0}};
    assign wshb_ifm.cti    = own0 ? wshb_ifs0.cti : own1 ? wshb_ifs1.cti : 3'd0;
    assign wshb_ifm.bte    = own0 ? wshb_ifs0.bte : own1 ? wshb_ifs1.bte : 2'd0;

    assign wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs1.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs0.ack    = own0 & wshb_ifm.ack;
    assign wshb_ifs0.err    = own0 & wshb_ifm.err;
    assign wshb_ifs0.rty    = own0 & wshb_ifm.rty;
    assign wshb_ifs1.ack    = own1 & wshb_ifm.ack;
    assign wshb_ifs1.err    = own1 & wshb_ifm.err;
    assign wshb_ifs1.rty    = own1 & wshb_ifm.rty;
endmodule

// File: tb/tb_wshb_arbiter.sv
// tb_wshb_arbiter: randomized scoreboard bench against an ownership-level reference model
module tb_wshb_arbiter;
    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [1:0] gnt;

    wshb_if #(.DATA_BYTES(4)) i0 ();
    wshb_if #(.DATA_BYTES(4)) i1 ();
    wshb_if #(.DATA_BYTES(4)) im ();

    wshb_arbiter #(.DATA_BYTES(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .wshb_ifs0 (i0),
        .wshb_ifs1 (i1),
        .wshb_ifm  (im),
        .gnt       (gnt)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [1:0]  gnt;
        logic        cyc;
        logic        stb;
        logic        rst;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dm;
        logic [2:0]  rsp0;
        logic [2:0]  rsp1;
        logic [31:0] dsm;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    int          owner = -1;
    int          last  = 1;
    logic [1:0]  cy, st, w;
    logic [31:0] ad[2], dm[2];
    logic        rs, sa, se, sr;
    logic [31:0] sd;
    logic [1:0]  got_rsp;
    int          cnt[2];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", n, act, req, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("gnt", {30'd0, gnt}, {30'd0, e.gnt});
            chk("m_cyc", {31'd0, im.cyc}, {31'd0, e.cyc});
            chk("m_stb", {31'd0, im.stb}, {31'd0, e.stb});
            chk("s0_rsp", {29'd0, i0.ack, i0.err, i0.rty}, {29'd0, e.rsp0});
            chk("s1_rsp", {29'd0, i1.ack, i1.err, i1.rty}, {29'd0, e.rsp1});
            chk("s0_dat_sm", i0.dat_sm, e.dsm);
            chk("s1_dat_sm", i1.dat_sm, e.dsm);
            if (!e.rst) begin
                chk("m_adr", im.adr, e.adr);
                chk("m_we", {31'd0, im.we}, {31'd0, e.we});
                chk("m_dat_ms", im.dat_ms, e.dm);
            end
        end
    end

    task automatic stimulus(input int k);
        for (int i = 0; i < 2; i++) begin
            ad[i] = $urandom;
            dm[i] = $urandom;
            w[i]  = 1'($urandom);
        end
        sd = $urandom;
        if (k < 2) begin
            rs = 1'b1;
            cy = 2'b11;
            st = 2'b11;
        end else if (k < 400) begin
            rs = $urandom_range(0, 49) == 0;
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 5) == 0) cy[i] = ~cy[i];
                st[i] = 1'($urandom);
            end
        end else if (k < 1200) begin
            rs = (k == 700 || k == 701);
            st = 2'b11;
            for (int i = 0; i < 2; i++) begin
                if (k == 400) begin
                    cnt[i] = 0;
                    cy[i]  = 1'b1;
                end else if (!cy[i]) begin
                    cy[i] = 1'b1;
                end else begin
                    if (got_rsp[i]) cnt[i]++;
                    if (cnt[i] == 16) begin
                        cy[i]  = 1'b0;
                        cnt[i] = 0;
                    end
                end
            end
        end else begin
            rs = $urandom_range(0, 39) == 0;
            cy = 2'($urandom);
            st = 2'($urandom);
        end
    endtask

    task automatic apply_and_expect(input int k);
        exp_t e;
        int   eo;
        int   o;
        logic has, live;
        eo   = rs ? -1 : owner;
        has  = eo >= 0;
        o    = has ? eo : 0;
        live = has && cy[o];
        if (k >= 400 && k < 1200) begin
            sa = live && st[o];
            se = 1'b0;
            sr = 1'b0;
        end else begin
            sa = live && st[o] && $urandom_range(0, 2) != 0;
            se = live && st[o] && !sa && $urandom_range(0, 3) == 0;
            sr = live && st[o] && !sa && !se && $urandom_range(0, 3) == 0;
        end
        i0.cyc = cy[0]; i0.stb = st[0]; i0.we = w[0]; i0.adr = ad[0]; i0.dat_ms = dm[0];
        i0.sel = 4'hf; i0.cti = 3'd2; i0.bte = 2'd0;
        i1.cyc = cy[1]; i1.stb = st[1]; i1.we = w[1]; i1.adr = ad[1]; i1.dat_ms = dm[1];
        i1.sel = 4'h3; i1.cti = 3'd7; i1.bte = 2'd1;
        im.ack = sa; im.err = se; im.rty = sr; im.dat_sm = sd;
        sys_rst = rs;
        e.gnt  = !has ? 2'b00 : eo == 0 ? 2'b01 : 2'b10;
        e.cyc  = live;
        e.stb  = live && st[o];
        e.rst  = rs;
        e.we   = has && w[o];
        e.adr  = has ? ad[o] : 32'd0;
        e.dm   = has ? dm[o] : 32'd0;
        e.rsp0 = (has && eo == 0) ? {sa, se, sr} : 3'b000;
        e.rsp1 = (has && eo == 1) ? {sa, se, sr} : 3'b000;
        e.dsm  = sd;
        got_rsp = {e.rsp1[2] | e.rsp1[1], e.rsp0[2] | e.rsp0[1]};
        q.push_back(e);
    endtask

    task automatic model_edge();
        logic held;
        if (rs) begin
            owner = -1;
            last  = 1;
        end else begin
            held = (owner == 0 && cy[0]) || (owner == 1 && cy[1]);
            if (!held) begin
                if (owner >= 0) owner = cy[1 - owner] ? 1 - owner : -1;
                else if (cy == 2'b11) owner = 1 - last;
                else owner = cy[0] ? 0 : cy[1] ? 1 : -1;
                if (owner >= 0) last = owner;
            end
        end
    endtask

    initial begin
        cy = 2'b00;
        st = 2'b00;
        w  = 2'b00;
        got_rsp = 2'b00;
        cnt[0] = 0;
        cnt[1] = 0;
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        for (int k = 0; k < 2000; k++) begin
            stimulus(k);
            apply_and_expect(k);
            @(posedge sys_clk);
            model_edge();
            #1;
        end
        @(negedge sys_clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
